// File: rtl/parafuzz_marker_pkg.sv
// Shared definitions for the phase-marker encoder: phase ids, the
// instruction field constants and the marker word encoder.
package parafuzz_marker_pkg;

  typedef enum logic [2:0] {
    PH_VCTM  = 3'd0,
    PH_DELAY = 3'd1,
    PH_TEXE  = 3'd2,
    PH_LEAK  = 3'd3,
    PH_INIT  = 3'd4,
    PH_BIM   = 3'd5,
    PH_TRAIN = 3'd6
  } phase_e;

  localparam logic [2:0]  PHASE_ILLEGAL = 3'd7;
  localparam logic [31:0] INST_NOP      = 32'h0000_0013;
  localparam logic [6:0]  SLTI_OPC      = 7'h13;
  localparam logic [2:0]  SLTI_FUNCT3   = 3'b010;

  // slti x0,x0,imm with imm = {8'd0, phase, is_end}
  function automatic logic [31:0] marker_enc(input logic [2:0] phase, input logic is_end);
    return {8'd0, phase, is_end, 5'd0, SLTI_FUNCT3, 5'd0, SLTI_OPC};
  endfunction

endpackage

// File: rtl/marker_fifo.sv
// Small request FIFO holding {phase,end} entries. Storage is a register
// array; the head entry is visible the cycle after it is written so an
// empty FIFO forwards a new request with one cycle of latency.
// The caller must never push when full or pop when empty.
module marker_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [3:0]               push_data,
  input  logic                     pop,
  output logic [3:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;

  // Entry storage; no reset so it maps onto plain memory
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign level = level_reg;
  assign full  = (level_reg == (AW+1)'(DEPTH));
  assign empty = (level_reg == '0);

endmodule

// File: rtl/phase_marker_gen.sv
// Phase-marker transmitter: checks phase nesting on incoming requests,
// buffers legal ones and emits them as slti x0,x0,imm marker words.
// Optional feature macro MARKER_GAP_EN: after every marker handshake,
// GAP_LEN NOP words are emitted, each needing its own handshake.
module phase_marker_gen
  import parafuzz_marker_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GAP_LEN = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_phase,
  input  logic        req_end,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_bits,
  output logic        open_valid,
  output logic [2:0]  open_phase,
  output logic        err_sticky,
  output logic [7:0]  err_count,
  output logic [31:0] emit_count
);

  localparam int LW = $clog2(DEPTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MARK = 2'd1;
`ifdef MARKER_GAP_EN
  localparam logic [1:0] ST_GAP  = 2'd2;
`endif

  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    fifo_head;
  logic [LW-1:0] fifo_level;
  logic [LW-1:0] level_next;

  logic accept;
  logic req_legal;
  logic push;
  logic pop;
  logic handshake;
  logic in_gap;
  logic have_next;

  logic [1:0]  state_reg, state_next;
  logic        open_valid_reg;
  logic [2:0]  open_phase_reg;
  logic        err_sticky_reg;
  logic [7:0]  err_count_reg;
  logic [31:0] emit_count_reg;
`ifdef MARKER_GAP_EN
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
`endif

  marker_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({req_phase, req_end}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Legality against the open state as it stood before this request
  always_comb begin
    req_legal = 1'b0;
    if (req_phase != PHASE_ILLEGAL) begin
      if (!req_end) req_legal = !open_valid_reg;
      else          req_legal = open_valid_reg && (req_phase == open_phase_reg);
    end
  end

  // Illegal requests are still consumed so the requester never stalls on them
  assign req_ready = !fifo_full;
  assign accept    = req_valid && !fifo_full;
  assign push      = accept && req_legal;

`ifdef MARKER_GAP_EN
  assign in_gap = (state_reg == ST_GAP);
`else
  assign in_gap = 1'b0;
`endif

  assign inst_valid = in_gap || !fifo_empty;
  assign handshake  = inst_valid && inst_ready;
  assign pop        = handshake && !in_gap;
  assign level_next = fifo_level + LW'(push) - LW'(pop);
  assign have_next  = (level_next != '0);

  // Output word: NOP during a gap, otherwise the encoded FIFO head
  always_comb begin
    inst_bits = 32'd0;
    if (in_gap)           inst_bits = INST_NOP;
    else if (!fifo_empty) inst_bits = marker_enc(fifo_head[3:1], fifo_head[0]);
  end

  // Presentation FSM next-state
  always_comb begin
    state_next = have_next ? ST_MARK : ST_IDLE;
`ifdef MARKER_GAP_EN
    gap_cnt_next = gap_cnt_reg;
    if (in_gap) begin
      state_next = ST_GAP;
      if (handshake) begin
        if (gap_cnt_reg <= 8'd1) state_next = have_next ? ST_MARK : ST_IDLE;
        else                     gap_cnt_next = gap_cnt_reg - 8'd1;
      end
    end else if (pop && (GAP_LEN != 0)) begin
      state_next   = ST_GAP;
      gap_cnt_next = 8'(GAP_LEN);
    end
`endif
  end

  // FSM state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
`ifdef MARKER_GAP_EN
      gap_cnt_reg <= 8'd0;
`endif
    end else begin
      state_reg <= state_next;
`ifdef MARKER_GAP_EN
      gap_cnt_reg <= gap_cnt_next;
`endif
    end
  end

  // Open-phase tracking, error accounting and marker counter
  always_ff @(posedge clock) begin
    if (reset) begin
      open_valid_reg <= 1'b0;
      open_phase_reg <= 3'd0;
      err_sticky_reg <= 1'b0;
      err_count_reg  <= 8'd0;
      emit_count_reg <= 32'd0;
    end else begin
      if (push) begin
        open_valid_reg <= !req_end;
        if (!req_end) open_phase_reg <= req_phase;
      end
      if (accept && !req_legal) begin
        err_sticky_reg <= 1'b1;
        if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
      end
      if (pop) emit_count_reg <= emit_count_reg + 32'd1;
    end
  end

  assign open_valid = open_valid_reg;
  assign open_phase = open_phase_reg;
  assign err_sticky = err_sticky_reg;
  assign err_count  = err_count_reg;
  assign emit_count = emit_count_reg;

endmodule

// File: tb/tb_phase_marker_gen.sv
// Bench for phase_marker_gen: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_phase_marker_gen;

  localparam int DEPTH   = 4;
  localparam int GAP_LEN = 2;
`ifdef MARKER_GAP_EN
  localparam int GAP_MODEL = GAP_LEN;
`else
  localparam int GAP_MODEL = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_phase = 3'd0;
  logic        req_end = 1'b0;
  logic        inst_ready = 1'b0;
  logic        req_ready;
  logic        inst_valid;
  logic [31:0] inst_bits;
  logic        open_valid;
  logic [2:0]  open_phase;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic [31:0] emit_count;

  phase_marker_gen #(.DEPTH(DEPTH), .GAP_LEN(GAP_LEN)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_phase(req_phase), .req_end(req_end),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_bits(inst_bits),
    .open_valid(open_valid), .open_phase(open_phase),
    .err_sticky(err_sticky), .err_count(err_count), .emit_count(emit_count)
  );

  always #5 clock = ~clock;

  // reference model state
  logic [31:0] mq[$];
  logic        m_open;
  logic [2:0]  m_phase;
  int          m_err;
  logic        m_sticky;
  logic [31:0] m_emit;
  int          m_gap;
  logic [31:0] hs_words[$];

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] word_of(input int ph, input int e);
    return 32'h0000_2013 | (32'(ph * 2 + e) << 20);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_open = 1'b0; m_phase = 3'd0; m_err = 0; m_sticky = 1'b0; m_emit = 32'd0; m_gap = 0;
  endtask

  // one clock edge of the specified behaviour, using the inputs just sampled
  task automatic model_step();
    bit exp_v, full, legal;
    int ph;
    if (reset) begin
      model_reset();
      return;
    end
    exp_v = (m_gap > 0) || (mq.size() > 0);
    full  = (mq.size() >= DEPTH);
    if (exp_v && inst_ready) begin
      if (m_gap > 0) m_gap--;
      else begin
        void'(mq.pop_front());
        m_emit++;
        m_gap = GAP_MODEL;
      end
    end
    if (req_valid && !full) begin
      ph = int'(req_phase);
      if (ph == 7)      legal = 0;
      else if (!req_end) legal = !m_open;
      else              legal = m_open && (req_phase == m_phase);
      if (legal) begin
        mq.push_back(word_of(ph, int'(req_end)));
        m_open = !req_end;
        if (!req_end) m_phase = req_phase;
      end else begin
        m_sticky = 1'b1;
        if (m_err < 255) m_err++;
      end
    end
  endtask

  task automatic check_all();
    bit exp_v;
    exp_v = (m_gap > 0) || (mq.size() > 0);
    chk("req_ready", {31'd0, req_ready}, {31'd0, mq.size() < DEPTH});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, exp_v});
    if (exp_v) chk("inst_bits", inst_bits, (m_gap > 0) ? 32'h0000_0013 : mq[0]);
    chk("open_valid", {31'd0, open_valid}, {31'd0, m_open});
    chk("open_phase", {29'd0, open_phase}, {29'd0, m_phase});
    chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
    chk("err_count", {24'd0, err_count}, 32'(m_err));
    chk("emit_count", emit_count, m_emit);
  endtask

  // one cycle: drive at the falling edge, model at the rising edge, compare at the next falling edge
  task automatic cyc(input bit rv, input int ph, input bit en, input bit ir, input bit rst);
    req_valid = rv; req_phase = ph[2:0]; req_end = en; inst_ready = ir; reset = rst;
    if (!rst && inst_valid && ir) begin
      hs_words.push_back(inst_bits);
      $display("[TB] t=%0t word %h handshaken", $time, inst_bits);
    end
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  initial begin
    int ph;
    bit en;
    logic [31:0] bp_words [4];
    model_reset();
    @(negedge clock);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

`ifndef MARKER_GAP_EN
    // legal pair START/END INIT
    cyc(1, 4, 0, 1, 0);
    chk("pair_first", inst_bits, 32'h0080_2013);
    cyc(1, 4, 1, 1, 0);
    chk("pair_second", inst_bits, 32'h0090_2013);
    cyc(0, 0, 0, 1, 0);
    chk("pair_emit", emit_count, 32'd2);
    chk("pair_sticky", {31'd0, err_sticky}, 32'd0);

    // backpressure: fill all four entries
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    chk("bp_head", inst_bits, 32'h0000_2013);
    cyc(0, 0, 0, 0, 0);
    chk("bp_head_held", inst_bits, 32'h0000_2013);
    bp_words = '{32'h0000_2013, 32'h0010_2013, 32'h0020_2013, 32'h0030_2013};
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain", inst_bits, bp_words[i]);
      cyc(0, 0, 0, 1, 0);
    end
    chk("bp_empty", {31'd0, inst_valid}, 32'd0);
`endif

    // nesting error
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    chk("nest_err_count", {24'd0, err_count}, 32'd1);
    chk("nest_sticky", {31'd0, err_sticky}, 32'd1);
    chk("nest_open_phase", {29'd0, open_phase}, 32'd0);
    cyc(1, 0, 1, 1, 0);

    // illegal END with none open, then phase 7
    cyc(0, 0, 0, 0, 1);
    cyc(1, 5, 1, 1, 0);
    cyc(1, 7, 0, 1, 0);
    chk("illegal_count", {24'd0, err_count}, 32'd2);
    chk("illegal_none", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < 300; i++) cyc(1, 7, i[0], 1, 0);
    chk("err_saturate", {24'd0, err_count}, 32'd255);

    // reset with three entries buffered and a word presented
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 5, 0, 0, 0);
    chk("prerst_valid", {31'd0, inst_valid}, 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_mid_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_mid_open", {31'd0, open_valid}, 32'd0);
    chk("rst_mid_err", {24'd0, err_count}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);

`ifdef MARKER_GAP_EN
    // START+END TRAIN back to back in gap mode
    hs_words.delete();
    cyc(1, 6, 0, 1, 0);
    cyc(1, 6, 1, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);
    begin
      logic [31:0] gap_exp [6];
      gap_exp = '{32'h00c0_2013, 32'h0000_0013, 32'h0000_0013,
                  32'h00d0_2013, 32'h0000_0013, 32'h0000_0013};
      chk("gap_len", 32'(hs_words.size()), 32'd6);
      for (int i = 0; i < 6; i++)
        if (i < hs_words.size()) chk("gap_seq", hs_words[i], gap_exp[i]);
    end
`endif

    // randomized traffic against the model
    cyc(0, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        if (m_open) begin ph = int'(m_phase); en = 1'b1; end
        else begin ph = int'($urandom_range(0, 6)); en = 1'b0; end
      end else begin
        ph = int'($urandom_range(0, 7));
        en = 1'($urandom_range(0, 1));
      end
      cyc($urandom_range(0, 3) != 0, ph, en, $urandom_range(0, 2) != 0,
          $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
